// File: rtl/rotation_tracker_pkg.sv
// rotation_pkg
// Shared types and width helpers for the rotation tracker.
//   rot_state_t  : lock state machine encoding
//   SLICE_IDX_W  : slice index width for the default geometry
//   SECTOR_W     : sector index width for the default geometry
package rotation_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } rot_state_t;

    localparam int DEF_N_SENSORS         = 2;
    localparam int DEF_SLICES_PER_SECTOR = 128;

    localparam int SLICE_IDX_W = $clog2(DEF_N_SENSORS * DEF_SLICES_PER_SECTOR);
    localparam int SECTOR_W    = (DEF_N_SENSORS > 1) ? $clog2(DEF_N_SENSORS) : 1;

endpackage

// File: rtl/rotation_tracker_if.sv
// rotation_tracker_if
// Bundles the sensor inputs and the position outputs of the rotation tracker.
//   hall_n        : raw active-low Hall sensor pins
//   slice_cnt     : absolute slice index
//   position_sync : one-cycle pulse at every slice start
//   locked        : slice outputs are valid
//   period        : last measured sector length in cycles
// Modports: master = sensor/consumer side, slave = tracker.
interface rotation_tracker_if #(
    parameter int N_SENSORS    = 2,
    parameter int SLICE_IDX_W  = rotation_pkg::SLICE_IDX_W,
    parameter int PERIOD_WIDTH = 32
);
    logic [N_SENSORS-1:0]    hall_n;
    logic [SLICE_IDX_W-1:0]  slice_cnt;
    logic                    position_sync;
    logic                    locked;
    logic [PERIOD_WIDTH-1:0] period;

    modport master (
        output hall_n,
        input  slice_cnt,
        input  position_sync,
        input  locked,
        input  period
    );

    modport slave (
        input  hall_n,
        output slice_cnt,
        output position_sync,
        output locked,
        output period
    );
endinterface

// File: rtl/rotation_tracker_hall_debounce.sv
// hall_debounce
// Two-flop synchroniser followed by a stable-count filter for one Hall sensor.
//   clk, nrst  : system clock, async active-low reset
//   i_hall_n   : raw asynchronous sensor pin, 0 = magnet present
//   o_active   : filtered level, 1 = magnet present
// The filtered level only flips once the synchronised input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts
// the count.
module hall_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_hall_n,
    output logic o_active
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_active;
    logic [CNT_W-1:0] r_stable_cnt;
    logic             w_differs;

    assign w_differs = (~r_sync2) != r_active;
    assign o_active  = r_active;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_active     <= 1'b0;
            r_stable_cnt <= '0;
        end else begin
            r_sync1 <= i_hall_n;
            r_sync2 <= r_sync1;
            if (w_differs) begin
                if (r_stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_active     <= ~r_sync2;
                    r_stable_cnt <= '0;
                end else begin
                    r_stable_cnt <= r_stable_cnt + CNT_W'(1);
                end
            end else begin
                r_stable_cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/rotation_tracker.sv
// rotation_tracker
// Turns N evenly spaced Hall sensors into an absolute angular slice index.
// Each sector is timed; slice pulses inside a sector are spaced with a
// remainder-carrying accumulator so truncation never accumulates.
//   clk, nrst : system clock, async active-low reset
//   bus       : rotation_tracker_if.slave (hall_n in; slice_cnt,
//               position_sync, locked, period out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// UNLOCKED | no sector timing yet, outputs idle
// ACQUIRE  | one top seen, next top yields a valid period
// LOCKED   | period valid, slice pulses generated
module rotation_tracker
    import rotation_pkg::*;
#(
    parameter int     N_SENSORS         = 2,
    parameter int     SLICES_PER_SECTOR = 128,
    parameter int     PERIOD_WIDTH      = 32,
    parameter int     DEBOUNCE_CYCLES   = 16,
    parameter longint TIMEOUT_CYCLES    = 2**24
) (
    input  logic             clk,
    input  logic             nrst,
    rotation_tracker_if.slave bus
);
    localparam int IDX_W = $clog2(N_SENSORS * SLICES_PER_SECTOR);
    localparam int SEC_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
    localparam int SUB_W = $clog2(SLICES_PER_SECTOR);
    localparam int ACC_W = PERIOD_WIDTH + 1;
    localparam logic [PERIOD_WIDTH-1:0] TIMEOUT   = PERIOD_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [SUB_W-1:0]        SUB_LAST  = SUB_W'(SLICES_PER_SECTOR - 1);
    localparam logic [ACC_W-1:0]        ACC_STEP  = ACC_W'(SLICES_PER_SECTOR);

    logic [N_SENSORS-1:0]    w_active;
    logic                    w_any;
    logic [SEC_W-1:0]        w_low_idx;

    logic                    r_armed;
    logic                    r_top;
    logic [SEC_W-1:0]        r_top_idx;

    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic                    w_timeout;

    rot_state_t              r_state;
    rot_state_t              w_state_next;
    logic                    w_slice_top;
    logic                    w_slice_step;

    logic [ACC_W-1:0]        r_acc;
    logic [ACC_W-1:0]        w_acc_sum;
    logic                    w_cross;
    logic [SUB_W-1:0]        r_sub;
    logic [SEC_W-1:0]        r_sector;
    logic                    r_sync;

    for (genvar g = 0; g < N_SENSORS; g++) begin : g_sensor
        hall_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .nrst     (nrst),
            .i_hall_n (bus.hall_n[g]),
            .o_active (w_active[g])
        );
    end

    assign w_any = |w_active;

    // Descending scan so the lowest active sensor wins simultaneous triggers.
    always_comb begin
        w_low_idx = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_low_idx = SEC_W'(i);
            end
        end
    end

    // One top per magnet pass: disarm on trigger, rearm only when every
    // sensor has gone quiet, so overlapping sensors cannot double-trigger.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_armed   <= 1'b1;
            r_top     <= 1'b0;
            r_top_idx <= '0;
        end else begin
            r_top <= r_armed && w_any;
            if (r_armed && w_any) begin
                r_armed   <= 1'b0;
                r_top_idx <= w_low_idx;
            end else if (!w_any) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_timeout = (r_cnt == TIMEOUT);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt    <= '0;
            r_period <= '0;
        end else if (r_top) begin
            r_period <= r_cnt;
            r_cnt    <= PERIOD_WIDTH'(1);
        end else if (!w_timeout) begin
            r_cnt <= r_cnt + PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= UNLOCKED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A top always beats a simultaneous timeout.
    always_comb begin
        w_state_next = r_state;
        w_slice_top  = 1'b0;
        w_slice_step = 1'b0;
        case (r_state)
            UNLOCKED: begin
                if (r_top) begin
                    w_state_next = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (r_top) begin
                    w_state_next = LOCKED;
                    w_slice_top  = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = UNLOCKED;
                end
            end
            LOCKED: begin
                if (r_top) begin
                    w_slice_top = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = UNLOCKED;
                end else begin
                    w_slice_step = 1'b1;
                end
            end
            default: begin
                w_state_next = UNLOCKED;
            end
        endcase
    end

    // acc holds the slice phase scaled by the period: adding S per cycle and
    // subtracting the period per slice keeps the remainder, so pulses land
    // on ceil(j*period/S) without a divider.
    assign w_acc_sum = r_acc + ACC_STEP;
    assign w_cross   = w_acc_sum >= {1'b0, r_period};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc    <= '0;
            r_sub    <= '0;
            r_sector <= '0;
            r_sync   <= 1'b0;
        end else begin
            r_sync <= 1'b0;
            if (w_slice_top) begin
                r_acc    <= '0;
                r_sub    <= '0;
                r_sector <= r_top_idx;
                r_sync   <= 1'b1;
            end else if (w_slice_step && (r_sub != SUB_LAST)) begin
                // Once the last slice of a sector is out, acc is frozen until
                // the next top so it cannot grow without bound.
                if (w_cross) begin
                    r_acc  <= w_acc_sum - {1'b0, r_period};
                    r_sub  <= r_sub + SUB_W'(1);
                    r_sync <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end
        end
    end

    assign bus.slice_cnt     = IDX_W'(r_sector) * IDX_W'(SLICES_PER_SECTOR) + IDX_W'(r_sub);
    assign bus.position_sync = r_sync;
    assign bus.locked        = (r_state == LOCKED);
    assign bus.period        = r_period;

endmodule
